// File: rtl/branch_resolve.sv
// ID-stage branch resolution: holds the IF/ID register, resolves beq/bne/j/jal,
// redirects fetch, and squashes wrong-path deliveries after a taken redirect.
module branch_resolve #(
    parameter int SQUASH = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IR_in,
    input  logic [31:0]      nPC_in,
    input  logic             stall,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic [4:0]       rs_addr,
    output logic [4:0]       rt_addr,
    output logic [31:0]      IR_out,
    output logic [31:0]      nPC_out,
    output logic             valid_out,
    output logic             PCSrc,
    output logic [31:0]      BrDest,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [1:0] SQ_INIT = 2'(SQUASH - 1);

    typedef enum logic {
        ST_RUN,
        ST_SQUASH
    } state_t;

    state_t           state;
    logic [1:0]       sq_cnt;
    logic [31:0]      ir_q;
    logic [31:0]      npc_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic [5:0]  opcode;
    logic        is_jump;
    logic        is_beq;
    logic        is_bne;
    logic [31:0] imm_ext;
    logic        take;

    assign opcode  = ir_q[31:26];
    assign is_jump = (opcode == OP_J) || (opcode == OP_JAL);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_bne  = (opcode == OP_BNE);
    assign imm_ext = {{16{ir_q[15]}}, ir_q[15:0]};

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        take = 1'b0;
        if (valid_q && !stall && state == ST_RUN) begin
            if (is_jump)
                take = 1'b1;
            else if (is_beq)
                take = (rs_data == rt_data);
            else if (is_bne)
                take = (rs_data != rt_data);
        end
    end

    assign BrDest    = is_jump ? {npc_q[31:26], ir_q[25:0]} : npc_q + imm_ext;
    assign PCSrc     = take;
    assign rs_addr   = ir_q[25:21];
    assign rt_addr   = ir_q[20:16];
    assign IR_out    = ir_q;
    assign nPC_out   = npc_q;
    assign valid_out = valid_q;
    assign taken_cnt = cnt_q;

    // sq_cnt holds the bubbles still owed after the take edge; the take edge
    // itself is the first one, so SQUASH=1 never enters ST_SQUASH.
    // NOTE: state is updated with non-blocking assignments so all registers
    // see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            sq_cnt  <= 2'd0;
            ir_q    <= 32'h0;
            npc_q   <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else if (!stall) begin
            case (state)
                ST_RUN: begin
                    npc_q <= nPC_in;
                    if (take) begin
                        ir_q    <= 32'h0;
                        valid_q <= 1'b0;
                        sq_cnt  <= SQ_INIT;
                        state   <= (SQUASH > 1) ? ST_SQUASH : ST_RUN;
                        if (cnt_q != {CNT_W{1'b1}})
                            cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        ir_q    <= IR_in;
                        valid_q <= 1'b1;
                    end
                end
                ST_SQUASH: begin
                    ir_q    <= 32'h0;
                    npc_q   <= nPC_in;
                    valid_q <= 1'b0;
                    if (sq_cnt <= 2'd1) begin
                        state  <= ST_RUN;
                        sq_cnt <= 2'd0;
                    end else begin
                        sq_cnt <= sq_cnt - 2'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule
